// File: rtl/iob_spi_slave_fl.sv
// SPI flash responder: oversampled mode-0 SPI target that answers READ, PAGE PROGRAM,
// READ STATUS, WREN/WRDI and JEDEC ID, serving data through a byte-wide memory port.
module iob_spi_slave_fl #(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hC22018
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_STATUS, S_ID, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {WEL_NONE, WEL_SET, WEL_CLR} wel_op_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;

  logic [2:0]        sclk_sync_q;
  logic [2:0]        ss_sync_q;
  logic [1:0]        mosi_sync_q;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        tx_cnt_q, tx_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [22:0]       addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_read_q, is_read_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              wel_q, wel_d;
  wel_op_t           wel_op_q, wel_op_d;
  logic              extra_q, extra_d;
  logic              pp_q, pp_d;
  logic              rd_wait_q, rd_wait_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic [7:0]        byte_in;
  logic [23:0]       addr_full;
  logic [ADDR_W-1:0] addr_inc;
  logic [7:0]        status_byte;
  logic [7:0]        id_byte;

  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
  assign mosi_s      = mosi_sync_q[1];
  assign byte_in     = {rx_q, mosi_s};
  assign addr_full   = {addr_sh_q, mosi_s};
  assign addr_inc    = addr_q + 1'b1;
  assign status_byte = {6'b0, wel_q, 1'b0};

  always_comb begin
    case (byte_cnt_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_d        = rx_q;
    addr_sh_d   = addr_sh_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    wel_d       = wel_q;
    wel_op_d    = wel_op_q;
    extra_d     = extra_q;
    pp_d        = pp_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_wait_d   = mem_en_q & ~mem_we_q;

    // Read data returns one cycle after the strobe; only a live read consumes it.
    if (rd_wait_q && state_q == S_RDATA) tx_d = mem_rdata;

    if (ss_rise) begin
      state_d   = S_IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = 3'd0;
      tx_cnt_d  = 3'd0;
      rx_d      = 7'd0;
      if (pp_q)                                  wel_d = 1'b0;
      else if (!extra_q && wel_op_q == WEL_SET)  wel_d = 1'b1;
      else if (!extra_q && wel_op_q == WEL_CLR)  wel_d = 1'b0;
      wel_op_d  = WEL_NONE;
      extra_d   = 1'b0;
      pp_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ss_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            rx_d      = 7'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            rx_d      = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = 2'd0;
              tx_cnt_d   = 3'd0;
              case (byte_in)
                CMD_READ: begin
                  state_d   = S_ADDR;
                  is_read_d = 1'b1;
                end
                CMD_PP: begin
                  pp_d      = 1'b1;
                  is_read_d = 1'b0;
                  state_d   = wel_q ? S_ADDR : S_IGNORE;
                end
                CMD_RDSR: begin
                  state_d = S_STATUS;
                  tx_d    = status_byte;
                end
                CMD_RDID: begin
                  state_d    = S_ID;
                  tx_d       = JEDEC_ID[23:16];
                  byte_cnt_d = 2'd1;
                end
                CMD_WREN: begin
                  state_d  = S_IGNORE;
                  wel_op_d = WEL_SET;
                end
                CMD_WRDI: begin
                  state_d  = S_IGNORE;
                  wel_op_d = WEL_CLR;
                end
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            addr_sh_d = addr_full[22:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd2) begin
                addr_d   = addr_full[ADDR_W-1:0];
                tx_cnt_d = 3'd0;
                if (is_read_q) begin
                  state_d    = S_RDATA;
                  mem_en_d   = 1'b1;
                  mem_addr_d = addr_full[ADDR_W-1:0];
                end else begin
                  state_d = S_WDATA;
                end
              end
            end
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            miso_d   = tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
            tx_cnt_d = tx_cnt_q + 3'd1;
            // Prefetch the next byte while bit 0 is on the wire.
            if (tx_cnt_q == 3'd7) begin
              mem_en_d   = 1'b1;
              mem_addr_d = addr_inc;
              addr_d     = addr_inc;
            end
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            rx_d      = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_wdata_d = byte_in;
              mem_addr_d  = addr_q;
              addr_d      = addr_inc;
            end
          end
        end
        S_STATUS: begin
          if (sclk_fall) begin
            miso_d   = tx_q[7];
            tx_cnt_d = tx_cnt_q + 3'd1;
            tx_d     = (tx_cnt_q == 3'd7) ? status_byte : {tx_q[6:0], 1'b0};
          end
        end
        S_ID: begin
          if (sclk_fall) begin
            miso_d   = tx_q[7];
            tx_cnt_d = tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd7) begin
              tx_d       = id_byte;
              byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        S_IGNORE: begin
          if (sclk_rise) extra_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      tx_cnt_q    <= 3'd0;
      byte_cnt_q  <= 2'd0;
      rx_q        <= 7'd0;
      addr_sh_q   <= 23'd0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      tx_q        <= 8'd0;
      miso_q      <= 1'b0;
      wel_q       <= 1'b0;
      wel_op_q    <= WEL_NONE;
      extra_q     <= 1'b0;
      pp_q        <= 1'b0;
      rd_wait_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      ss_sync_q   <= {ss_sync_q[1:0], ss};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_q        <= rx_d;
      addr_sh_q   <= addr_sh_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      wel_q       <= wel_d;
      wel_op_q    <= wel_op_d;
      extra_q     <= extra_d;
      pp_q        <= pp_d;
      rd_wait_q   <= rd_wait_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign miso      = miso_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_iob_spi_slave_fl.sv
// Bench for iob_spi_slave_fl: SPI master tasks plus a scoreboard monitor that checks
// every memory strobe and every byte received on miso against queued expectations.
module tb_iob_spi_slave_fl;
  localparam int AW = 8;
  localparam int H  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          ss;
  logic          mosi;
  logic          miso;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0] wmem   [256];
  logic       wvalid [256];

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       exp_mem_q [$];
  logic [7:0] exp_q     [$];
  logic [7:0] act_q     [$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  iob_spi_slave_fl #(.ADDR_W(AW), .JEDEC_ID(24'hC22018)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory: unwritten location a holds (a - 0x10), so 0x10.. reads 0x00, 0x01, ...
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= (wvalid[mem_addr] === 1'b1) ? wmem[mem_addr] : mem_addr - 8'd16;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    acc_t       a;
    logic [7:0] e;
    logic [7:0] g;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        total++;
        if (exp_mem_q.size() == 0) begin
          bad++;
          $display("FAIL mem_unexpected: got we=%0b addr=%02h wdata=%02h, required no access",
                   mem_we, mem_addr, mem_wdata);
        end else begin
          a = exp_mem_q.pop_front();
          if (mem_we !== a.we || mem_addr !== a.addr || (a.we && mem_wdata !== a.data)) begin
            bad++;
            $display("FAIL mem_access: got we=%0b addr=%02h wdata=%02h, required we=%0b addr=%02h wdata=%02h",
                     mem_we, mem_addr, mem_wdata, a.we, a.addr, a.data);
          end else begin
            $display("mem ok: we=%0b addr=%02h wdata=%02h", mem_we, mem_addr, mem_wdata);
          end
        end
      end
      if (act_q.size() != 0) begin
        g = act_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL miso_byte: got %02h required %02h", g, e);
        end else begin
          $display("miso ok: %02h", g);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("check ok %s: %0h", name, act);
    end
  endtask

  task automatic exp_rd(input int a);
    acc_t x;
    x.we = 1'b0; x.addr = 8'(a); x.data = 8'h00;
    exp_mem_q.push_back(x);
  endtask

  task automatic exp_wr(input int a, input logic [7:0] d);
    acc_t x;
    x.we = 1'b1; x.addr = 8'(a); x.data = d;
    exp_mem_q.push_back(x);
  endtask

  task automatic bit_x(input logic b, output logic r);
    mosi = b;
    repeat (H) @(negedge clk);
    r = miso;
    sclk = 1'b1;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic byte_x(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] rx;
    logic       r;
    exp_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      bit_x(tx[i], r);
      rx[i] = r;
    end
    act_q.push_back(rx);
  endtask

  task automatic ss_low();
    ss = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic ss_high(input string name);
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    check(name, {31'd0, miso}, 32'd0);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] addr);
    byte_x(cmd, 8'h00);
    byte_x(addr[23:16], 8'h00);
    byte_x(addr[15:8], 8'h00);
    byte_x(addr[7:0], 8'h00);
  endtask

  task automatic status(input logic [7:0] exp);
    ss_low();
    byte_x(8'h05, 8'h00);
    byte_x(8'h00, exp);
    byte_x(8'h00, exp);
    ss_high("status_idle_miso");
  endtask

  task automatic wren();
    ss_low();
    byte_x(8'h06, 8'h00);
    ss_high("wren_idle_miso");
  endtask

  initial begin
    logic r;
    rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Read four bytes from 0x10, plus the prefetch of 0x14.
    for (int a = 16; a < 21; a++) exp_rd(a);
    ss_low();
    hdr(8'h03, 24'h000010);
    byte_x(8'h00, 8'h00);
    byte_x(8'h00, 8'h01);
    byte_x(8'h00, 8'h02);
    byte_x(8'h00, 8'h03);
    ss_high("read_idle_miso");

    // Program without WEL: no write.
    ss_low();
    hdr(8'h02, 24'h000020);
    byte_x(8'hAA, 8'h00);
    ss_high("pp_nowel_idle_miso");

    wren();
    status(8'h02);

    // Program with WEL.
    exp_wr(8'h20, 8'hA5);
    exp_wr(8'h21, 8'h5A);
    ss_low();
    hdr(8'h02, 24'h000020);
    byte_x(8'hA5, 8'h00);
    byte_x(8'h5A, 8'h00);
    ss_high("pp_idle_miso");
    status(8'h00);

    // Read back the programmed bytes.
    exp_rd(8'h20); exp_rd(8'h21); exp_rd(8'h22);
    ss_low();
    hdr(8'h03, 24'h000020);
    byte_x(8'h00, 8'hA5);
    byte_x(8'h00, 8'h5A);
    ss_high("readback_idle_miso");

    // Address wrap with ADDR_W=8.
    exp_rd(8'hFE); exp_rd(8'hFF); exp_rd(8'h00); exp_rd(8'h01);
    ss_low();
    hdr(8'h03, 24'h0000FE);
    byte_x(8'h00, 8'hEE);
    byte_x(8'h00, 8'hEF);
    byte_x(8'h00, 8'hF0);
    ss_high("wrap_idle_miso");

    // JEDEC ID.
    ss_low();
    byte_x(8'h9F, 8'h00);
    byte_x(8'h00, 8'hC2);
    byte_x(8'h00, 8'h20);
    byte_x(8'h00, 8'h18);
    byte_x(8'h00, 8'h00);
    ss_high("id_idle_miso");

    // PP aborted after 5 data bits: no write, WEL cleared.
    wren();
    ss_low();
    hdr(8'h02, 24'h000030);
    for (int i = 0; i < 5; i++) bit_x(1'b1, r);
    ss_high("pp_abort_idle_miso");
    status(8'h00);

    // WREN followed by a ninth bit is not honoured.
    ss_low();
    byte_x(8'h06, 8'h00);
    bit_x(1'b0, r);
    ss_high("wren9_idle_miso");
    status(8'h00);

    // Reset in the middle of a read.
    exp_rd(8'h40); exp_rd(8'h41);
    ss_low();
    hdr(8'h03, 24'h000040);
    byte_x(8'h00, 8'h30);
    for (int i = 0; i < 3; i++) bit_x(1'b0, r);
    repeat (H) @(negedge clk);
    check("pre_rst_miso", {31'd0, miso}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    ss_high("post_rst_idle_miso");
    status(8'h00);

    repeat (20) @(negedge clk);
    check("exp_mem_drained", exp_mem_q.size(), 32'd0);
    check("exp_byte_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_spi_slave_fl.md
# iob_spi_slave_fl

SPI flash responder: the target side of the flash SPI link, answering a subset of serial-flash commands (read, page program, status, write enable/disable, JEDEC ID) over SCLK/SS/MOSI/MISO. It is fully synchronous to the system clock: it oversamples the SPI pins and serves data from a byte-wide memory port. It is used as the on-chip flash model in simulation and FPGA loopback against the flash SPI master, and as a flash-emulation target.

## Interface

- ADDR_W, 24: memory address width; the low ADDR_W bits of the 24-bit command address are used.
- JEDEC_ID, 24'hC22018: value returned by command 0x9F, MSB first.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- ss  input  1  slave select, active-low, asynchronous to clk.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first; 0 when not driving data.
- mem_en  output  1  memory access strobe, one-cycle pulse.
- mem_we  output  1  write qualifier, valid with mem_en.
- mem_addr  output  ADDR_W  byte address.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte, valid exactly 1 clk after mem_en with mem_we=0.

## Operation

- sclk, ss and mosi each pass through a 2-flop synchronizer; sclk and ss edges are detected on the synchronized copies.
- ss rising edge, observed at any point, aborts the transaction: partial byte discarded, no write, FSM to IDLE.
- MOSI sampled on sclk rising edge; miso updated on sclk falling edge. Bit counter 0..7 within each byte.
- FSM states: IDLE, CMD, ADDR, RDATA, WDATA, STATUS, ID, IGNORE.
  - IDLE -> CMD on ss falling edge; bit counter cleared.
  - CMD: after 8 bits, decode:
    - 0x03 READ -> ADDR.
    - 0x02 PAGE PROGRAM -> ADDR when WEL=1, else IGNORE.
    - 0x05 READ STATUS -> STATUS.
    - 0x9F -> ID.
    - 0x06 / 0x04 -> IGNORE with a pending set/clear of WEL.
    - Any other value -> IGNORE.
  - ADDR: 24 bits, MSB first. After the last bit: READ -> RDATA, PP -> WDATA.
  - RDATA:
    - On entry, issue a read (mem_en=1, mem_we=0) at addr.
    - mem_rdata loads the output shift register; bit 7 appears on the next sclk falling edge.
    - The next read (addr+1) is issued when bit 0 is driven.
    - Reads continue indefinitely.
  - WDATA:
    - Each complete received byte -> one cycle with mem_en=1, mem_we=1, mem_wdata=byte, mem_addr=addr; then addr increments.
  - Address arithmetic: addr increments modulo 2^ADDR_W (ADDR_W'h…FF wraps to 0); no page wrap.
  - STATUS: outputs {6'b0, WEL, 1'b0} repeatedly; WIP is always 0.
  - ID: outputs the 3 bytes of JEDEC_ID, then 0x00 until ss rises.
  - IGNORE: miso=0, all input ignored.
- WEL rules:
  - Pending WREN/WRDI takes effect on ss rising edge only if exactly 8 bits were received.
  - WEL clears on ss rising edge after any PP transaction, including a PP with zero data bytes.
- Reset, including mid-transaction: FSM=IDLE, WEL=0, addr=0, bit counter=0, shift registers=0; no memory access is issued in the reset cycle.

## Timing

- Reset values: miso=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Synchronizer plus edge detect: an internal event occurs 3 clk after the pin edge.
- miso changes 3–4 clk after sclk falls.
- Timing constraints on the SPI side:
  - sclk high and low times ≥ 4 clk each.
  - ss setup to the first sclk rise ≥ 4 clk.
  - ss high time ≥ 4 clk.
- mem_en is a single-cycle pulse. At most one access is in flight. Read data is captured exactly 1 clk after mem_en.
- A write pulse occurs 1 clk after the internal rising edge that completes the byte.
- miso = 0 whenever ss is high, the FSM is in CMD/ADDR/IGNORE, or the FSM is idle.

## Test plan

- Read: memory preloaded with 0x00..0xFF at addr 0x000010+; send 0x03 0x00 0x00 0x10, then clock 4 bytes -> miso returns 0x00,0x01,0x02,0x03; mem_en reads at 0x10..0x13.
- Program without WEL: send 0x02 0x000020 0xAA -> no mem_we pulse. Then send 0x06 (ss toggle), then 0x05 -> status byte 0x02.
- Program with WEL: send 0x02 0x000020 0xA5 0x5A -> writes 0xA5 at 0x20 and 0x5A at 0x21. A following 0x05 returns 0x00 (WEL cleared).
- Wrap-around: with ADDR_W=8, read from 0xFE for 3 bytes -> reads at addresses 0xFE, 0xFF, 0x00.
- ID: send 0x9F and clock 4 bytes -> 0xC2, 0x20, 0x18, 0x00.
- Aborts:
  - ss raised after 5 data bits of a PP byte -> no write.
  - WREN with 9 bits -> WEL stays 0.
  - rst asserted mid-read -> miso=0 and mem_en=0 the next cycle; the next 0x05 returns 0x00.
